// File: rtl/gen_arb_pkg.sv
// Shared types for the gen_arbn request/ack arbiter slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: main FSM states (one-hot), per-port FSM states, timeout counter
// width, and a helper that sizes port-index fields.
package gen_arb_pkg;

   // Timeout counter width; covers TMO_CYC up to 65535.
   localparam int TMO_W = 16;

   // One-hot so dev_req / p_ack / p_err each decode from a single state bit.
   typedef enum logic [3:0] {
      M_IDLE = 4'b0001,
      M_BUSY = 4'b0010,
      M_CMPL = 4'b0100,
      M_GAP  = 4'b1000
   } main_st_t;

   typedef enum logic [1:0] {
      P_IDLE = 2'd0,
      P_PEND = 2'd1,
      P_DONE = 2'd2
   } port_st_t;

   // Width of a port index; never below one bit.
   function automatic int idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/gen_arb_rr_pick.sv
// Combinational winner picker over the pending-port mask.
// Latency: zero (pure combinational).
// Backpressure: none; gnt_vld is low when nothing is pending.
// Ports:
//   pend     in   NPORT  ports eligible for grant
//   ptr      in   IW     last granted port (round-robin only)
//   rr_en    in   1      1 = search from ptr+1 wrapping, 0 = lowest index wins
//   gnt      out  NPORT  one-hot winner
//   gnt_idx  out  IW     winner index
//   gnt_vld  out  1      a winner exists
module gen_arb_rr_pick #(
   parameter int NPORT = 4,
   parameter int IW    = 2
) (
   input  logic [NPORT-1:0] pend,
   input  logic [IW-1:0]    ptr,
   input  logic             rr_en,
   output logic [NPORT-1:0] gnt,
   output logic [IW-1:0]    gnt_idx,
   output logic             gnt_vld
);

   always_comb begin : pick
      // One spare bit so ptr+1+k can exceed NPORT-1 before the wrap.
      logic [IW:0]   cand;
      logic [IW-1:0] idx;
      gnt     = '0;
      gnt_idx = '0;
      gnt_vld = 1'b0;
      cand    = '0;
      idx     = '0;
      for (int k = 0; k < NPORT; k++) begin
         if (rr_en) begin
            cand = {1'b0, ptr} + (IW+1)'(k + 1);
            if (cand >= (IW+1)'(NPORT)) begin
               cand = cand - (IW+1)'(NPORT);
            end
            idx = cand[IW-1:0];
         end else begin
            idx = IW'(k);
         end
         if (!gnt_vld && pend[idx]) begin
            gnt_vld   = 1'b1;
            gnt[idx]  = 1'b1;
            gnt_idx   = idx;
         end
      end
   end

endmodule

// File: rtl/gen_arbn.sv
// N-port request/ack arbiter onto one device port, round-robin or fixed priority, optional ack timeout.
// Latency: p_req seen at edge t -> dev_req after t+1; dev_ack at edge a -> p_ack during the cycle after a+1.
// Backpressure: one device access in flight; other requests stay pending, grants are never preempted.
// Ports:
//   dev_clk, dev_rst_n            clock, async active-low reset
//   dev_addr/wdata/be/wr/req      registered device request, dev_req held until dev_ack or timeout
//   dev_rdata, dev_ack            device completion (ack is a one-cycle pulse)
//   p_addr/wdata/be/wr/req        packed per-port requests, port i at slice i
//   p_rdata                       per-port read data, held until that port's next completion
//   p_ack, p_err                  one-cycle completion pulse; p_err marks a timeout
module gen_arbn
   import gen_arb_pkg::*;
#(
   parameter int               NPORT   = 4,
   parameter int               AW      = 32,
   parameter int               DW      = 32,
   parameter logic [NPORT-1:0] P_SIZE8 = '0,
   parameter int               RR_EN   = 1,
   parameter int               TMO_CYC = 0
) (
   input  logic                  dev_clk,
   input  logic                  dev_rst_n,
   output logic [AW-1:0]         dev_addr,
   output logic [DW-1:0]         dev_wdata,
   output logic [DW/8-1:0]       dev_be,
   output logic                  dev_wr,
   output logic                  dev_req,
   input  logic [DW-1:0]         dev_rdata,
   input  logic                  dev_ack,
   input  logic [NPORT*AW-1:0]   p_addr,
   input  logic [NPORT*DW-1:0]   p_wdata,
   input  logic [NPORT*DW/8-1:0] p_be,
   input  logic [NPORT-1:0]      p_wr,
   input  logic [NPORT-1:0]      p_req,
   output logic [NPORT*DW-1:0]   p_rdata,
   output logic [NPORT-1:0]      p_ack,
   output logic [NPORT-1:0]      p_err
);

   localparam int BEW = DW / 8;
   localparam int IW  = idx_w(NPORT);

   typedef struct packed {
      logic [AW-1:0]  addr;
      logic [DW-1:0]  wdata;
      logic [BEW-1:0] be;
      logic           wr;
   } txn_t;

   txn_t             port_txn [NPORT];
   txn_t             txn_q;
   logic [NPORT-1:0] pend;
   logic [NPORT-1:0] gnt;
   logic [NPORT-1:0] win_oh;
   logic [IW-1:0]    gnt_idx;
   logic [IW-1:0]    rr_ptr;
   logic             gnt_vld;
   main_st_t         st;
   main_st_t         st_nxt;
   logic [DW-1:0]    cap_rdata;
   logic             tmo_hit;
   logic [TMO_W-1:0] tmo_cnt;
   logic             tmo_exp;

   // ---------------------------------------------------------------
   // Per-port request unpack, port FSM and read-data holding register
   // ---------------------------------------------------------------
   for (genvar i = 0; i < NPORT; i++) begin : g_port
      port_st_t      pst;
      port_st_t      pst_nxt;
      logic [DW-1:0] rd_q;
      logic          own_done;

      assign port_txn[i] = {p_addr[i*AW +: AW], p_wdata[i*DW +: DW],
                            p_be[i*BEW +: BEW], p_wr[i]};

      // Completion is taken in CMPL so DONE and p_ack line up.
      assign own_done = (st == M_CMPL) && win_oh[i];

      always_ff @(posedge dev_clk or negedge dev_rst_n) begin
         if (!dev_rst_n) begin
            pst <= P_IDLE;
         end else begin
            pst <= pst_nxt;
         end
      end

      always_comb begin
         pst_nxt = pst;
         case (pst)
            P_IDLE:  if (p_req[i])  pst_nxt = P_PEND;
            P_PEND:  if (own_done)  pst_nxt = P_DONE;
            // Holding here until p_req drops gives one access per request.
            P_DONE:  if (!p_req[i]) pst_nxt = P_IDLE;
            default: pst_nxt = P_IDLE;
         endcase
      end

      assign pend[i] = (pst == P_PEND);

      // Timed-out accesses leave the previous data in place.
      always_ff @(posedge dev_clk or negedge dev_rst_n) begin
         if (!dev_rst_n) begin
            rd_q <= '0;
         end else if (own_done && !tmo_hit) begin
            rd_q <= P_SIZE8[i] ? {BEW{cap_rdata[7:0]}} : cap_rdata;
         end
      end

      assign p_rdata[i*DW +: DW] = rd_q;
   end

   gen_arb_rr_pick #(
      .NPORT (NPORT),
      .IW    (IW)
   ) u_pick (
      .pend    (pend),
      .ptr     (rr_ptr),
      .rr_en   (RR_EN != 0),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .gnt_vld (gnt_vld)
   );

   // An ack on the expiry clock wins over the timeout.
   assign tmo_exp = (TMO_CYC != 0) && (st == M_BUSY) && !dev_ack &&
                    (tmo_cnt == TMO_W'(TMO_CYC - 1));

   // ---------------------------------------------------------------
   // Main FSM: state register / next state / outputs
   // ---------------------------------------------------------------
   always_ff @(posedge dev_clk or negedge dev_rst_n) begin
      if (!dev_rst_n) begin
         st <= M_IDLE;
      end else begin
         st <= st_nxt;
      end
   end

   always_comb begin
      st_nxt = st;
      case (st)
         M_IDLE:  if (gnt_vld)             st_nxt = M_BUSY;
         M_BUSY:  if (dev_ack || tmo_exp)  st_nxt = M_CMPL;
         M_CMPL:  st_nxt = M_GAP;
         // GAP keeps dev_req rising edges at least four clocks apart.
         M_GAP:   st_nxt = M_IDLE;
         default: st_nxt = M_IDLE;
      endcase
   end

   // Decoded from one-hot state bits, so dev_req drops with the async reset.
   always_comb begin
      dev_req = (st == M_BUSY);
      p_ack   = (st == M_GAP) ? win_oh : '0;
      p_err   = ((st == M_GAP) && tmo_hit) ? win_oh : '0;
   end

   // ---------------------------------------------------------------
   // Grant latch, device capture and timeout counter
   // ---------------------------------------------------------------
   always_ff @(posedge dev_clk or negedge dev_rst_n) begin
      if (!dev_rst_n) begin
         txn_q     <= '0;
         win_oh    <= '0;
         rr_ptr    <= IW'(NPORT - 1);
         cap_rdata <= '0;
         tmo_hit   <= 1'b0;
         tmo_cnt   <= '0;
      end else begin
         case (st)
            M_IDLE: begin
               if (gnt_vld) begin
                  txn_q   <= port_txn[gnt_idx];
                  win_oh  <= gnt;
                  rr_ptr  <= gnt_idx;
                  tmo_cnt <= '0;
                  tmo_hit <= 1'b0;
               end
            end
            M_BUSY: begin
               tmo_cnt <= tmo_cnt + TMO_W'(1);
               if (dev_ack) begin
                  cap_rdata <= dev_rdata;
               end else if (tmo_exp) begin
                  tmo_hit <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign dev_addr  = txn_q.addr;
   assign dev_wdata = txn_q.wdata;
   assign dev_be    = txn_q.be;
   assign dev_wr    = txn_q.wr;

endmodule

// File: tb/tb_gen_arbn.sv
// Directed bench for gen_arbn: DUT A is round-robin with byte-replicated port 0
// and an 8-clock ack timeout; DUT B is fixed priority without timeout.
// Stimulus and device model share one set of drivers, steered by sel.
module tb_gen_arbn;

   typedef logic [1:0] pidx_t;

   logic          dev_clk = 1'b0;
   logic          dev_rst_n = 1'b0;
   always #5 dev_clk = ~dev_clk;

   logic [127:0]  p_addr;
   logic [127:0]  p_wdata;
   logic [15:0]   p_be;
   logic [3:0]    p_wr;
   logic [31:0]   dev_rdata;

   logic          sel;
   logic [3:0]    req_drv;
   logic          ack_drv;

   logic [3:0]    p_req_a, p_req_b;
   logic          dev_ack_a, dev_ack_b;
   logic [31:0]   dev_addr_a, dev_addr_b, dev_wdata_a, dev_wdata_b;
   logic [3:0]    dev_be_a, dev_be_b;
   logic          dev_wr_a, dev_wr_b, dev_req_a, dev_req_b;
   logic [127:0]  p_rdata_a, p_rdata_b;
   logic [3:0]    p_ack_a, p_ack_b, p_err_a, p_err_b;

   assign p_req_a   = sel ? 4'b0000 : req_drv;
   assign p_req_b   = sel ? req_drv : 4'b0000;
   assign dev_ack_a = !sel && ack_drv;
   assign dev_ack_b = sel && ack_drv;

   logic          cur_dev_req, cur_dev_wr;
   logic [31:0]   cur_dev_addr, cur_dev_wdata;
   logic [127:0]  cur_p_rdata;
   logic [3:0]    cur_p_ack, cur_p_err;
   assign cur_dev_req   = sel ? dev_req_b   : dev_req_a;
   assign cur_dev_wr    = sel ? dev_wr_b    : dev_wr_a;
   assign cur_dev_addr  = sel ? dev_addr_b  : dev_addr_a;
   assign cur_dev_wdata = sel ? dev_wdata_b : dev_wdata_a;
   assign cur_p_rdata   = sel ? p_rdata_b   : p_rdata_a;
   assign cur_p_ack     = sel ? p_ack_b     : p_ack_a;
   assign cur_p_err     = sel ? p_err_b     : p_err_a;

   gen_arbn #(.NPORT(4), .AW(32), .DW(32), .P_SIZE8(4'b0001), .RR_EN(1), .TMO_CYC(8)) u_dut_a (
      .dev_clk(dev_clk), .dev_rst_n(dev_rst_n),
      .dev_addr(dev_addr_a), .dev_wdata(dev_wdata_a), .dev_be(dev_be_a), .dev_wr(dev_wr_a),
      .dev_req(dev_req_a), .dev_rdata(dev_rdata), .dev_ack(dev_ack_a),
      .p_addr(p_addr), .p_wdata(p_wdata), .p_be(p_be), .p_wr(p_wr), .p_req(p_req_a),
      .p_rdata(p_rdata_a), .p_ack(p_ack_a), .p_err(p_err_a)
   );

   gen_arbn #(.NPORT(4), .AW(32), .DW(32), .P_SIZE8(4'b0000), .RR_EN(0), .TMO_CYC(0)) u_dut_b (
      .dev_clk(dev_clk), .dev_rst_n(dev_rst_n),
      .dev_addr(dev_addr_b), .dev_wdata(dev_wdata_b), .dev_be(dev_be_b), .dev_wr(dev_wr_b),
      .dev_req(dev_req_b), .dev_rdata(dev_rdata), .dev_ack(dev_ack_b),
      .p_addr(p_addr), .p_wdata(p_wdata), .p_be(p_be), .p_wr(p_wr), .p_req(p_req_b),
      .p_rdata(p_rdata_b), .p_ack(p_ack_b), .p_err(p_err_b)
   );

   logic [31:0] addr_tab  [4];
   logic [31:0] wdata_tab [4];
   logic        wr_tab    [4];

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge dev_clk);
      #1;
   endtask

   function automatic logic [31:0] rd_of(input pidx_t p);
      return 32'(cur_p_rdata >> {p, 5'd0});
   endfunction

   // Waits (bounded) for dev_req and checks the latched request belongs to port.
   task automatic wait_grant(input pidx_t port);
      int n;
      n = 0;
      while (!cur_dev_req && n < 40) begin
         step();
         n++;
      end
      chk("grant_seen", cur_dev_req, 1);
      chk("grant_addr", cur_dev_addr, addr_tab[port]);
      chk("grant_wr", cur_dev_wr, wr_tab[port]);
      chk("grant_wdata", cur_dev_wdata, wdata_tab[port]);
   endtask

   // Acks on the k-th BUSY clock, then checks completion on port with expected data.
   task automatic finish(input pidx_t port, input int k, input logic [31:0] rd, input logic [31:0] exp);
      dev_rdata = rd;
      repeat (k - 1) step();
      chk("busy_hold", cur_dev_req, 1);
      chk("no_preempt", cur_dev_addr, addr_tab[port]);
      ack_drv = 1'b1;
      step();
      ack_drv = 1'b0;
      chk("req_drop", cur_dev_req, 0);
      chk("no_early_ack", cur_p_ack, 0);
      step();
      chk("p_ack", cur_p_ack, 4'b0001 << port);
      chk("p_err_clear", cur_p_err, 0);
      chk("p_rdata", rd_of(port), exp);
      req_drv[port] = 1'b0;
      step();
      chk("ack_pulse_end", cur_p_ack, 0);
      chk("gap_idle", cur_dev_req, 0);
   endtask

   initial begin
      addr_tab[0]  = 32'h0000_0040; addr_tab[1]  = 32'h0000_0080;
      addr_tab[2]  = 32'h0000_0100; addr_tab[3]  = 32'h0000_0200;
      wdata_tab[0] = 32'hD000_0000; wdata_tab[1] = 32'hD111_1111;
      wdata_tab[2] = 32'hD222_2222; wdata_tab[3] = 32'hD333_3333;
      wr_tab[0] = 1'b0; wr_tab[1] = 1'b1; wr_tab[2] = 1'b0; wr_tab[3] = 1'b0;
      for (int i = 0; i < 4; i++) begin
         p_addr[i*32 +: 32]  = addr_tab[i];
         p_wdata[i*32 +: 32] = wdata_tab[i];
         p_be[i*4 +: 4]      = 4'hF;
         p_wr[i]             = wr_tab[i];
      end
      sel = 1'b0; req_drv = 4'b0000; ack_drv = 1'b0; dev_rdata = '0;
      dev_rst_n = 1'b0;

      // Reset state
      step(); step();
      chk("rst_dev_req", dev_req_a, 0);
      chk("rst_dev_addr", dev_addr_a, 0);
      chk("rst_p_ack", p_ack_a, 0);
      chk("rst_p_err", p_err_a, 0);
      chk("rst_p_rdata", p_rdata_a, 0);
      chk("rst_dev_req_b", dev_req_b, 0);
      dev_rst_n = 1'b1;
      step();

      // 1: single read on port 2, ack on third BUSY clock, latency check
      req_drv[2] = 1'b1;
      step();
      chk("lat_pend", cur_dev_req, 0);
      step();
      chk("lat_req", cur_dev_req, 1);
      wait_grant(2);
      finish(2, 3, 32'hA5A5_1234, 32'hA5A5_1234);

      // 2: byte-replicated port 0
      req_drv[0] = 1'b1;
      wait_grant(0);
      finish(0, 2, 32'h1122_3344, 32'h4444_4444);

      // 3: round-robin from a fresh pointer
      dev_rst_n = 1'b0;
      step();
      dev_rst_n = 1'b1;
      step();
      req_drv = 4'b1111;
      wait_grant(0); finish(0, 1, 32'h0000_00AB, 32'hABAB_ABAB);
      wait_grant(1); finish(1, 2, 32'h1111_0001, 32'h1111_0001);
      wait_grant(2); finish(2, 1, 32'h2222_0002, 32'h2222_0002);
      wait_grant(3); finish(3, 1, 32'h3333_0003, 32'h3333_0003);
      req_drv = 4'b0101;
      wait_grant(0); finish(0, 1, 32'h0000_0012, 32'h1212_1212);
      wait_grant(2); finish(2, 1, 32'h2222_0022, 32'h2222_0022);
      // pointer now 2: port 3 is searched before port 0
      req_drv = 4'b1001;
      wait_grant(3); finish(3, 1, 32'h3333_0033, 32'h3333_0033);
      wait_grant(0); finish(0, 1, 32'h0000_00CD, 32'hCDCD_CDCD);

      // 5: timeout after 8 BUSY clocks, late ack ignored
      req_drv[3] = 1'b1;
      dev_rdata = 32'hDEAD_BEEF;
      wait_grant(3);
      repeat (7) step();
      chk("tmo_hold", cur_dev_req, 1);
      step();
      chk("tmo_drop", cur_dev_req, 0);
      ack_drv = 1'b1;
      step();
      ack_drv = 1'b0;
      chk("tmo_p_ack", cur_p_ack, 4'b1000);
      chk("tmo_p_err", cur_p_err, 4'b1000);
      chk("tmo_rdata_kept", rd_of(3), 32'h3333_0033);
      req_drv[3] = 1'b0;
      step();
      chk("tmo_ack_end", cur_p_ack, 0);
      chk("tmo_err_end", cur_p_err, 0);
      step(); step();
      chk("idle_quiet", cur_dev_req, 0);
      chk("idle_no_ack", cur_p_ack, 0);
      // ack on the expiry clock wins
      req_drv[3] = 1'b1;
      wait_grant(3);
      finish(3, 8, 32'h0BAD_F00D, 32'h0BAD_F00D);

      // 6: reset during BUSY
      req_drv[1] = 1'b1;
      wait_grant(1);
      step();
      dev_rst_n = 1'b0;
      #1;
      chk("rst_async_req", cur_dev_req, 0);
      req_drv[1] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rst_no_ack", cur_p_ack, 0);
      end
      chk("rst_rdata_clr", cur_p_rdata, 0);
      dev_rst_n = 1'b1;
      step();
      chk("post_rst_idle", cur_dev_req, 0);
      req_drv[1] = 1'b1;
      wait_grant(1);
      finish(1, 2, 32'hFACE_0001, 32'hFACE_0001);

      // 4: fixed priority on DUT B, port 0 arrives while port 1 is BUSY
      step();
      sel = 1'b1;
      req_drv = 4'b1010;
      wait_grant(1);
      req_drv[0] = 1'b1;
      finish(1, 3, 32'h5555_AAAA, 32'h5555_AAAA);
      wait_grant(0); finish(0, 1, 32'h0000_0011, 32'h0000_0011);
      wait_grant(3); finish(3, 2, 32'h3030_3030, 32'h3030_3030);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

endmodule
